// File: rtl/minn_pkg.sv
// rtl/minn_pkg.sv - shared types and defaults for the Minn detector and symbol framer
package minn_pkg;

  localparam int SAMPLE_WIDTH   = 12;
  localparam int NFFT_DEFAULT   = 2048;
  localparam int CP_LEN_DEFAULT = 512;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BODY = 2'd1,
    ST_CP   = 2'd2
  } framer_state_t;

  typedef struct packed {
    logic signed [SAMPLE_WIDTH-1:0] ch0_i;
    logic signed [SAMPLE_WIDTH-1:0] ch0_q;
    logic signed [SAMPLE_WIDTH-1:0] ch1_i;
    logic signed [SAMPLE_WIDTH-1:0] ch1_q;
  } sample_t;

  // Counter width that never collapses to zero bits for degenerate sizes.
  function automatic int clog2_min1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating event counter with synchronous clear
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (clear) begin
      count <= '0;
    end else if (inc && (count != {WIDTH{1'b1}})) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/ofdm_symbol_framer.sv
// rtl/ofdm_symbol_framer.sv - cuts CP-free NFFT windows per OFDM symbol; FRAMER_STATS_EN adds stats
module ofdm_symbol_framer
  import minn_pkg::*;
#(
  parameter int INPUT_WIDTH    = SAMPLE_WIDTH,
  parameter int NFFT           = NFFT_DEFAULT,
  parameter int CP_LEN         = CP_LEN_DEFAULT,
  parameter int SYMS_PER_FRAME = 14,
  parameter int SYM_IDX_WIDTH  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  input  logic signed [INPUT_WIDTH-1:0] in_ch0_i,
  input  logic signed [INPUT_WIDTH-1:0] in_ch0_q,
  input  logic signed [INPUT_WIDTH-1:0] in_ch1_i,
  input  logic signed [INPUT_WIDTH-1:0] in_ch1_q,
  input  logic                          in_frame_start,
  output logic                          out_valid,
  output logic signed [INPUT_WIDTH-1:0] out_ch0_i,
  output logic signed [INPUT_WIDTH-1:0] out_ch0_q,
  output logic signed [INPUT_WIDTH-1:0] out_ch1_i,
  output logic signed [INPUT_WIDTH-1:0] out_ch1_q,
  output logic                          out_sym_start,
  output logic                          out_sym_last,
  output logic [SYM_IDX_WIDTH-1:0]      out_sym_idx,
  output logic                          frame_done,
  output logic                          busy
`ifdef FRAMER_STATS_EN
  ,
  output logic [15:0]                   stat_frames,
  output logic [15:0]                   stat_dropped_starts
`endif
);

  localparam int BODY_W = clog2_min1(NFFT);
  localparam int CP_W   = clog2_min1(CP_LEN + 1);
  localparam logic [BODY_W-1:0]        BODY_LAST = BODY_W'(NFFT - 1);
  localparam logic [CP_W-1:0]          CP_END    = CP_W'(CP_LEN);
  localparam logic [SYM_IDX_WIDTH-1:0] IDX_LAST  = SYM_IDX_WIDTH'(SYMS_PER_FRAME - 1);

  framer_state_t            state, state_nxt;
  logic [BODY_W-1:0]        body_cnt, body_nxt;
  logic [CP_W-1:0]          cp_cnt, cp_nxt;
  logic [SYM_IDX_WIDTH-1:0] sym_idx, idx_nxt;

  logic                     take_body;
  logic [BODY_W-1:0]        pos;
  logic [SYM_IDX_WIDTH-1:0] cur_idx;
  logic                     emit_start;
  logic                     emit_last;
  logic                     emit_done;
  logic                     drop_start;

  always_comb begin
    state_nxt  = state;
    body_nxt   = body_cnt;
    cp_nxt     = cp_cnt;
    idx_nxt    = sym_idx;
    take_body  = 1'b0;
    pos        = '0;
    cur_idx    = sym_idx;
    emit_last  = 1'b0;
    emit_done  = 1'b0;
    drop_start = 1'b0;

    if (in_valid) begin
      case (state)
        ST_IDLE: begin
          if (in_frame_start) begin
            take_body = 1'b1;
            cur_idx   = '0;
          end
        end
        ST_BODY: begin
          take_body  = 1'b1;
          pos        = body_cnt;
          drop_start = in_frame_start;
        end
        ST_CP: begin
          drop_start = in_frame_start;
          // The sample after CP_LEN discards is already body sample 0 of the next symbol.
          if (cp_cnt == CP_END) begin
            take_body = 1'b1;
            cur_idx   = sym_idx + SYM_IDX_WIDTH'(1);
          end else begin
            cp_nxt = cp_cnt + CP_W'(1);
          end
        end
        default: state_nxt = ST_IDLE;
      endcase

      if (take_body) begin
        idx_nxt = cur_idx;
        if (pos == BODY_LAST) begin
          emit_last = 1'b1;
          body_nxt  = '0;
          cp_nxt    = '0;
          if (cur_idx == IDX_LAST) begin
            emit_done = 1'b1;
            state_nxt = ST_IDLE;
          end else begin
            state_nxt = ST_CP;
          end
        end else begin
          body_nxt  = pos + BODY_W'(1);
          state_nxt = ST_BODY;
        end
      end
    end
  end

  assign emit_start = take_body && (pos == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      body_cnt      <= '0;
      cp_cnt        <= '0;
      sym_idx       <= '0;
      out_valid     <= 1'b0;
      out_sym_start <= 1'b0;
      out_sym_last  <= 1'b0;
      frame_done    <= 1'b0;
      busy          <= 1'b0;
      out_ch0_i     <= '0;
      out_ch0_q     <= '0;
      out_ch1_i     <= '0;
      out_ch1_q     <= '0;
    end else begin
      state         <= state_nxt;
      body_cnt      <= body_nxt;
      cp_cnt        <= cp_nxt;
      sym_idx       <= idx_nxt;
      out_valid     <= take_body;
      out_sym_start <= emit_start;
      out_sym_last  <= emit_last;
      frame_done    <= emit_done;
      busy          <= (state_nxt != ST_IDLE);
      if (take_body) begin
        out_ch0_i <= in_ch0_i;
        out_ch0_q <= in_ch0_q;
        out_ch1_i <= in_ch1_i;
        out_ch1_q <= in_ch1_q;
      end
    end
  end

  // sym_idx only changes when a body sample is emitted, so it doubles as the held output tag.
  assign out_sym_idx = sym_idx;

`ifdef FRAMER_STATS_EN
  sat_counter #(.WIDTH(16)) u_frames_cnt (
    .clk   (clk),
    .clear (rst),
    .inc   (emit_done),
    .count (stat_frames)
  );

  sat_counter #(.WIDTH(16)) u_dropped_cnt (
    .clk   (clk),
    .clear (rst),
    .inc   (drop_start),
    .count (stat_dropped_starts)
  );
`else
  logic stats_unused;
  assign stats_unused = drop_start;
`endif

endmodule

// File: tb/tb_ofdm_symbol_framer.sv
// tb/tb_ofdm_symbol_framer.sv - randomized model-checked bench for ofdm_symbol_framer
module tb_ofdm_symbol_framer;

  localparam int W    = 12;
  localparam int NFFT = 16;
  localparam int CP   = 4;
  localparam int SYMS = 3;
  localparam int IW   = 4;

  logic clk = 1'b0;
  logic rst;
  logic in_valid;
  logic signed [W-1:0] in_ch0_i, in_ch0_q, in_ch1_i, in_ch1_q;
  logic in_frame_start;
  logic out_valid;
  logic signed [W-1:0] out_ch0_i, out_ch0_q, out_ch1_i, out_ch1_q;
  logic out_sym_start, out_sym_last, frame_done, busy;
  logic [IW-1:0] out_sym_idx;
`ifdef FRAMER_STATS_EN
  logic [15:0] stat_frames, stat_dropped_starts;
`endif

  always #5 clk = ~clk;

  ofdm_symbol_framer #(
    .INPUT_WIDTH(W), .NFFT(NFFT), .CP_LEN(CP), .SYMS_PER_FRAME(SYMS), .SYM_IDX_WIDTH(IW)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .in_ch0_i(in_ch0_i), .in_ch0_q(in_ch0_q), .in_ch1_i(in_ch1_i), .in_ch1_q(in_ch1_q),
    .in_frame_start(in_frame_start), .out_valid(out_valid),
    .out_ch0_i(out_ch0_i), .out_ch0_q(out_ch0_q), .out_ch1_i(out_ch1_i), .out_ch1_q(out_ch1_q),
    .out_sym_start(out_sym_start), .out_sym_last(out_sym_last), .out_sym_idx(out_sym_idx),
    .frame_done(frame_done), .busy(busy)
`ifdef FRAMER_STATS_EN
    , .stat_frames(stat_frames), .stat_dropped_starts(stat_dropped_starts)
`endif
  );

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: position k of each accepted sample counted from the flagged
  // start; symbol s occupies k in [s*(NFFT+CP), s*(NFFT+CP)+NFFT).
  logic            e_valid, e_start, e_last, e_done, e_busy;
  logic [4*W-1:0]  e_data;
  logic [IW-1:0]   e_idx;
  int              e_frames, e_drops;

  initial begin
    bit m_active;
    int m_k, s, r;
    m_active = 0; m_k = 0;
    e_valid = 0; e_start = 0; e_last = 0; e_done = 0; e_busy = 0;
    e_data = '0; e_idx = '0; e_frames = 0; e_drops = 0;
    forever begin
      @(posedge clk);
      if (rst) begin
        m_active = 0; m_k = 0;
        e_valid = 0; e_start = 0; e_last = 0; e_done = 0; e_busy = 0;
        e_data = '0; e_idx = '0; e_frames = 0; e_drops = 0;
      end else begin
        e_valid = 0; e_start = 0; e_last = 0; e_done = 0;
        if (in_valid) begin
          if (m_active && in_frame_start && e_drops < 65535) e_drops++;
          if (!m_active && in_frame_start) begin
            m_active = 1;
            m_k = 0;
          end
          if (m_active) begin
            s = m_k / (NFFT + CP);
            r = m_k % (NFFT + CP);
            if (r < NFFT) begin
              e_valid = 1;
              e_data  = {in_ch0_i, in_ch0_q, in_ch1_i, in_ch1_q};
              e_idx   = IW'(s);
              e_start = (r == 0);
              e_last  = (r == NFFT - 1);
              e_done  = (r == NFFT - 1) && (s == SYMS - 1);
            end
            if (e_done) begin
              m_active = 0;
              if (e_frames < 65535) e_frames++;
            end
            m_k++;
          end
        end
        e_busy = m_active;
      end
    end
  end

  logic [18:0] got_q[$];
  logic [18:0] exp_q[$];

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("ctrl", {59'd0, out_valid, out_sym_start, out_sym_last, frame_done, busy},
                  {59'd0, e_valid, e_start, e_last, e_done, e_busy});
      chk("data_idx", {8'd0, out_ch0_i, out_ch0_q, out_ch1_i, out_ch1_q, out_sym_idx},
                      {8'd0, e_data, e_idx});
`ifdef FRAMER_STATS_EN
      chk("stats", {32'd0, stat_frames, stat_dropped_starts},
                   {32'd0, e_frames[15:0], e_drops[15:0]});
`endif
      if (out_valid)
        got_q.push_back({out_ch0_i, out_sym_idx, out_sym_start, out_sym_last, frame_done});
    end
  end

  // Literal framing for a frame flagged at ramp value base, truncated before stop.
  task automatic add_frame(input int base, input int stop);
    int v;
    for (int s = 0; s < SYMS; s++)
      for (int r = 0; r < NFFT; r++) begin
        v = base + s * (NFFT + CP) + r;
        if (v < stop)
          exp_q.push_back({W'(v), IW'(s), r == 0, r == NFFT - 1,
                           (s == SYMS - 1) && (r == NFFT - 1)});
      end
  endtask

  task automatic step(input bit v, input bit fs, input bit r, input int n);
    in_valid       = v;
    in_frame_start = fs;
    rst            = r;
    in_ch0_i       = W'(n);
    in_ch0_q       = ~W'(n);
    in_ch1_i       = W'(n * 3);
    in_ch1_q       = W'($urandom);
    @(negedge clk);
  endtask

  task automatic run_scn(input string name, input int fs_a, input int fs_b, input int rst_at,
                         input int nsamp, input bit rnd);
    int n, cyc;
    bit v;
    n = 0; cyc = 0;
    while (n < nsamp && cyc < 4000) begin
      v = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      step(v, v && (n == fs_a || n == fs_b), v && (n == rst_at), n);
      if (v) n++;
      cyc++;
    end
    chk({name, "_budget"}, 64'(n), 64'(nsamp));
    repeat (4) step(0, 0, 0, 0);
    chk({name, "_len"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk({name, "_seq"}, 64'(got_q[i]), 64'(exp_q[i]));
  endtask

  task automatic reset_between;
    step(0, 0, 1, 0);
    step(0, 1, 1, 0);
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    step(0, 1, 1, 0);
    chk_en = 1'b1;
    chk("reset_outs", {out_valid, out_sym_start, out_sym_last, frame_done, busy, out_sym_idx,
                       out_ch0_i, out_ch0_q, out_ch1_i, out_ch1_q}, 64'd0);
    reset_between();

    add_frame(10, 1000);
    run_scn("ramp", 10, -1, -1, 80, 1'b0);
    reset_between();

    add_frame(10, 1000);
    run_scn("gaps", 10, -1, -1, 80, 1'b1);
    reset_between();

    add_frame(10, 1000);
    run_scn("dup_start", 10, 20, -1, 80, 1'b1);
`ifdef FRAMER_STATS_EN
    chk("stat_frames", 64'(stat_frames), 64'd1);
    chk("stat_dropped", 64'(stat_dropped_starts), 64'd1);
`endif
    reset_between();

    add_frame(10, 35);
    add_frame(40, 1000);
    run_scn("mid_rst", 10, 40, 35, 120, 1'b0);
    reset_between();

    add_frame(10, 1000);
    add_frame(66, 1000);
    run_scn("b2b", 10, 66, -1, 140, 1'b1);
    reset_between();

    run_scn("no_start", -1, -1, -1, 200, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
